// File: rtl/cache_req_arbiter_pkg.sv
// Shared constants and types for the cache request arbiter.
package cache_pkg;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic STATUS_OK  = 1'b0;
    localparam logic STATUS_ERR = 1'b1;

    // Latched request payload presented to the cache.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
    } req_t;

    // Only plain reads and writes are forwarded to the cache.
    function automatic logic op_legal(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester-side and cache-side bus of the arbiter.
// master = arbiter view, slave = environment (requesters + cache) view.
interface cache_req_arbiter_if;

    // requester side
    logic [1:0]  rq_valid;
    logic [31:0] rq0_address;
    logic [31:0] rq1_address;
    logic [1:0]  rq0_op;
    logic [1:0]  rq1_op;
    logic [31:0] rq0_wdata;
    logic [31:0] rq1_wdata;
    logic [1:0]  rq_ready;
    logic [1:0]  rs_valid;
    logic [31:0] rs_rdata;
    logic        rs_status;

    // cache side
    logic        req_valid;
    logic [31:0] req_address;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic [31:0] resp_rdata;
    logic        resp_valid;
    logic        resp_status;

    modport master (
        input  rq_valid, rq0_address, rq1_address, rq0_op, rq1_op,
               rq0_wdata, rq1_wdata, resp_rdata, resp_valid, resp_status,
        output rq_ready, rs_valid, rs_rdata, rs_status,
               req_valid, req_address, req_op, req_wdata
    );

    modport slave (
        output rq_valid, rq0_address, rq1_address, rq0_op, rq1_op,
               rq0_wdata, rq1_wdata, resp_rdata, resp_valid, resp_status,
        input  rq_ready, rs_valid, rs_rdata, rs_status,
               req_valid, req_address, req_op, req_wdata
    );

endinterface

// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin arbiter in front of the single cache port.
// One transaction in flight; illegal opcodes are answered locally and
// every cache access is bounded by a timeout. All outputs are registered:
// next-state output values are computed alongside the state transition.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                cclk,
    input  logic                cresetn,
    cache_req_arbiter_if.master bus,
    output logic                busy,
    output logic                stray_resp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic             req_valid_q, req_valid_d;
    logic [1:0]       rq_ready_q, rq_ready_d;
    logic [1:0]       rs_valid_q, rs_valid_d;
    logic [31:0]      rs_rdata_q, rs_rdata_d;
    logic             rs_status_q, rs_status_d;
    logic             busy_q, busy_d;
    logic             stray_q, stray_d;

    logic             sel;
    req_t             cand;

    // Round-robin pick: lone requester wins, a tie goes to the one not served last.
    always_comb begin
        sel  = (bus.rq_valid == 2'b11) ? ~last_q : bus.rq_valid[1];
        cand = sel ? '{addr: bus.rq1_address, op: bus.rq1_op, wdata: bus.rq1_wdata}
                   : '{addr: bus.rq0_address, op: bus.rq0_op, wdata: bus.rq0_wdata};
    end

    // Transition logic plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_valid_d = 1'b0;
        rq_ready_d  = 2'b00;
        rs_valid_d  = 2'b00;
        rs_rdata_d  = rs_rdata_q;
        rs_status_d = rs_status_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.rq_valid) begin
                    gnt_d      = sel;
                    last_d     = sel;
                    rq_ready_d = sel ? 2'b10 : 2'b01;
                    if (op_legal(cand.op)) begin
                        state_d     = ST_ISSUE;
                        req_d       = cand;
                        req_valid_d = 1'b1;
                    end else begin
                        // answered locally, the cache never sees it
                        state_d     = ST_RESP;
                        rs_valid_d  = sel ? 2'b10 : 2'b01;
                        rs_rdata_d  = 32'h0;
                        rs_status_d = STATUS_ERR;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a response on the timeout cycle still wins
                if (bus.resp_valid) begin
                    state_d     = ST_RESP;
                    rs_valid_d  = gnt_q ? 2'b10 : 2'b01;
                    rs_rdata_d  = bus.resp_rdata;
                    rs_status_d = bus.resp_status;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rs_valid_d  = gnt_q ? 2'b10 : 2'b01;
                    rs_rdata_d  = 32'h0;
                    rs_status_d = STATUS_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        stray_d = bus.resp_valid && (state_q != ST_WAIT);
    end

    // State and output registers; reset drops every pulse immediately.
    always_ff @(posedge cclk or negedge cresetn) begin
        if (!cresetn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            rq_ready_q  <= 2'b00;
            rs_valid_q  <= 2'b00;
            rs_rdata_q  <= 32'h0;
            rs_status_q <= 1'b0;
            busy_q      <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            rq_ready_q  <= rq_ready_d;
            rs_valid_q  <= rs_valid_d;
            rs_rdata_q  <= rs_rdata_d;
            rs_status_q <= rs_status_d;
            busy_q      <= busy_d;
            stray_q     <= stray_d;
        end
    end

    assign bus.req_valid   = req_valid_q;
    assign bus.req_address = req_q.addr;
    assign bus.req_op      = req_q.op;
    assign bus.req_wdata   = req_q.wdata;
    assign bus.rq_ready    = rq_ready_q;
    assign bus.rs_valid    = rs_valid_q;
    assign bus.rs_rdata    = rs_rdata_q;
    assign bus.rs_status   = rs_status_q;
    assign busy            = busy_q;
    assign stray_resp      = stray_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed vector table, hand-written
// reset/stray sequences, then random transactions against a
// transaction-level model. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_cache_req_arbiter;
    import cache_pkg::*;

    localparam int TO = 8;

    logic cclk    = 1'b0;
    logic cresetn = 1'b0;
    logic busy;
    logic stray_resp;

    cache_req_arbiter_if bus ();

    cache_req_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .cclk       (cclk),
        .cresetn    (cresetn),
        .bus        (bus),
        .busy       (busy),
        .stray_resp (stray_resp)
    );

    always #5 cclk = ~cclk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  rqv;
        logic [31:0] a0, w0, a1, w1;
        logic [1:0]  op0, op1;
        int          delay;      // WAIT cycle index of the cache response; >= TO means none
        logic [31:0] rdata;
        logic        rstat;
        logic        exp_g;
        logic        exp_legal;
        logic [31:0] exp_rd;
        logic        exp_st;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [1:0] oh;
        int eff;
        oh = v.exp_g ? 2'b10 : 2'b01;
        bus.rq_valid    = v.rqv;
        bus.rq0_address = v.a0;  bus.rq0_op = v.op0;  bus.rq0_wdata = v.w0;
        bus.rq1_address = v.a1;  bus.rq1_op = v.op1;  bus.rq1_wdata = v.w1;
        @(negedge cclk);
        chk("rq_ready", 32'(bus.rq_ready), 32'(oh));
        if (v.exp_legal) begin
            chk("req_valid", 32'(bus.req_valid), 32'd1);
            chk("req_address", bus.req_address, v.exp_g ? v.a1 : v.a0);
            chk("req_op", 32'(bus.req_op), 32'(v.exp_g ? v.op1 : v.op0));
            chk("req_wdata", bus.req_wdata, v.exp_g ? v.w1 : v.w0);
            chk("rs_valid_issue", 32'(bus.rs_valid), 32'd0);
            bus.rq_valid = 2'b00;
            eff = (v.delay < TO) ? v.delay : TO - 1;
            for (int i = 0; i <= eff; i++) begin
                @(negedge cclk);
                chk("rs_valid_wait", 32'(bus.rs_valid), 32'd0);
                if (i == v.delay) begin
                    bus.resp_valid  = 1'b1;
                    bus.resp_rdata  = v.rdata;
                    bus.resp_status = v.rstat;
                end
            end
            @(negedge cclk);
            bus.resp_valid = 1'b0;
            chk("req_valid_resp", 32'(bus.req_valid), 32'd0);
        end else begin
            bus.rq_valid = 2'b00;
            chk("req_valid_illegal", 32'(bus.req_valid), 32'd0);
        end
        chk("rs_valid", 32'(bus.rs_valid), 32'(oh));
        chk("rs_rdata", bus.rs_rdata, v.exp_rd);
        chk("rs_status", 32'(bus.rs_status), 32'(v.exp_st));
        @(negedge cclk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rs_valid_idle", 32'(bus.rs_valid), 32'd0);
        chk("stray_idle", 32'(stray_resp), 32'd0);
    endtask

    vec_t tbl[10];
    vec_t v;
    logic m_last;
    logic g;
    logic [1:0] op;
    logic lgl, tmo;

    initial begin
        bus.rq_valid    = 2'b00;
        bus.rq0_address = '0; bus.rq1_address = '0;
        bus.rq0_op      = '0; bus.rq1_op      = '0;
        bus.rq0_wdata   = '0; bus.rq1_wdata   = '0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_status = 1'b0;

        // fairness: ties alternate 0,1,0,1 from reset
        for (int i = 0; i < 4; i++)
            tbl[i] = '{2'b11, 32'h100 + 32'(i), 32'h0, 32'h200 + 32'(i), 32'h0, OP_READ, OP_READ,
                       2, 32'hA0 + 32'(i), 1'b0, 1'(i % 2), 1'b1, 32'hA0 + 32'(i), 1'b0};
        tbl[4] = '{2'b01, 32'h3001_8000, 32'h1800_32de, 32'h0, 32'h0, OP_WRITE, OP_READ,
                   5, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[5] = '{2'b10, 32'h0, 32'h0, 32'h44, 32'h0, OP_READ, 2'b11,
                   0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[6] = '{2'b01, 32'h80, 32'h0, 32'h0, 32'h0, OP_READ, OP_READ,
                   99, 32'hDEAD, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};
        tbl[7] = '{2'b10, 32'h0, 32'h0, 32'hC0, 32'h77, OP_READ, OP_WRITE,
                   TO - 1, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b1, 32'h5A5A_5A5A, 1'b0};
        tbl[8] = '{2'b01, 32'hF0, 32'h0, 32'h0, 32'h0, OP_READ, OP_READ,
                   0, 32'h1234, 1'b1, 1'b0, 1'b1, 32'h1234, 1'b1};
        tbl[9] = '{2'b11, 32'h10, 32'h0, 32'h20, 32'h0, OP_READ, 2'b00,
                   0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};

        // reset state
        repeat (2) @(negedge cclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_rq_ready", 32'(bus.rq_ready), 32'd0);
        chk("rst_rs_valid", 32'(bus.rs_valid), 32'd0);
        chk("rst_stray", 32'(stray_resp), 32'd0);
        cresetn = 1'b1;
        @(negedge cclk);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // late response after a timeout is dropped as stray
        run_txn('{2'b01, 32'h90, 32'h0, 32'h0, 32'h0, OP_READ, OP_READ,
                  99, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1});
        repeat (2) @(negedge cclk);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'hBAD0;
        @(negedge cclk);
        bus.resp_valid = 1'b0;
        chk("stray_pulse", 32'(stray_resp), 32'd1);
        chk("stray_no_rs", 32'(bus.rs_valid), 32'd0);
        @(negedge cclk);
        chk("stray_clear", 32'(stray_resp), 32'd0);
        chk("stray_rs_idle", 32'(bus.rs_valid), 32'd0);

        // asynchronous reset in the middle of WAIT
        bus.rq_valid = 2'b10; bus.rq1_op = OP_READ;
        @(negedge cclk);
        bus.rq_valid = 2'b00;
        repeat (2) @(negedge cclk);
        chk("busy_in_wait", 32'(busy), 32'd1);
        #2 cresetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("arst_rs_valid", 32'(bus.rs_valid), 32'd0);
        @(negedge cclk);
        cresetn = 1'b1;
        @(negedge cclk);
        bus.resp_valid = 1'b1;
        @(negedge cclk);
        bus.resp_valid = 1'b0;
        chk("post_rst_stray", 32'(stray_resp), 32'd1);
        chk("post_rst_no_rs", 32'(bus.rs_valid), 32'd0);
        @(negedge cclk);
        run_txn('{2'b11, 32'h11, 32'h0, 32'h22, 32'h33, OP_READ, OP_WRITE,
                  1, 32'h66, 1'b0, 1'b0, 1'b1, 32'h66, 1'b0});

        // random transactions against a transaction-level model
        m_last = 1'b0;
        for (int n = 0; n < 60; n++) begin
            v.rqv   = 2'($urandom_range(1, 3));
            v.a0    = $urandom; v.w0 = $urandom;
            v.a1    = $urandom; v.w1 = $urandom;
            v.op0   = 2'($urandom_range(0, 3));
            v.op1   = 2'($urandom_range(0, 3));
            v.delay = $urandom_range(0, TO + 2);
            v.rdata = $urandom;
            v.rstat = 1'($urandom_range(0, 1));
            if (v.rqv == 2'b11) g = ~m_last;
            else                g = (v.rqv == 2'b10);
            m_last = g;
            op  = g ? v.op1 : v.op0;
            lgl = (op == 2'b01) || (op == 2'b10);
            tmo = (v.delay >= TO);
            v.exp_g     = g;
            v.exp_legal = lgl;
            v.exp_rd    = (!lgl || tmo) ? 32'h0 : v.rdata;
            v.exp_st    = (!lgl || tmo) ? 1'b1 : v.rstat;
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
